latch_checker: RTL and testbench

Synthesizable scoreboard placed directly downstream of the D-latch under test. Each `clk` cycle it samples the latch gate (`en`), the data input (`d`) and the latch output (`q`), and runs a reference transparent-latch model. It compares the model's prediction, delayed by a fixed latency, against `q` and accumulates sample, error and first-error statistics over a start/stop measurement window. It turns latch stimulus runs into a single pass/fail result that the bench or an on-chip status register can read.

---
 rtl/latch_checker_pkg.sv | 23 ++
 rtl/latch_checker_ref_model.sv | 57 +++++
 rtl/latch_checker.sv | 124 ++++++++++++
 tb/tb_latch_checker.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/latch_checker_pkg.sv
// Shared definitions for the latch checker: FSM state encodings, the LAT
// bounds check and the prediction record carried down the delay line.
`timescale 1ns/1ps
package latch_checker_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;

    typedef struct packed {
        logic exp;
        logic vld;
    } pred_t;

    function automatic bit lat_ok(input int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/latch_checker_ref_model.sv
// Reference transparent-latch model plus a LAT-deep delay line that aligns
// each prediction with the latch output it should match.
`timescale 1ns/1ps
module latch_ref_model
    import latch_checker_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic exp_dly,
    output logic exp_vld_dly
);

    logic  ref_q_reg;
    logic  ref_known_reg;
    pred_t pred_chain [LAT+1];

    // A prediction is only trustworthy once the gate has opened at least once.
    assign pred_chain[0] = '{exp: (en ? d : ref_q_reg), vld: (en | ref_known_reg)};

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q_reg     <= 1'b0;
            ref_known_reg <= 1'b0;
        end else begin
            if (en) begin
                ref_q_reg <= d;
            end
            ref_known_reg <= clr ? 1'b0 : (ref_known_reg | en);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_dly
            pred_t stage_reg;

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= pred_chain[gi];
                end
            end

            assign pred_chain[gi+1] = stage_reg;
        end
    endgenerate

    assign exp_dly     = pred_chain[LAT].exp;
    assign exp_vld_dly = pred_chain[LAT].vld;

endmodule

// File: rtl/latch_checker.sv
// Latch scoreboard: FSM, sample/error/first-error statistics and the compare
// of the delayed reference prediction against the latch output q.
`timescale 1ns/1ps
module latch_checker
    import latch_checker_pkg::*;
#(
    parameter int LAT    = 1,
    parameter int CNT_W  = 16,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             d,
    input  logic             q,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err,
    output logic             first_err_vld
);

    localparam int               SET_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    generate
        if (!lat_ok(LAT) || SETTLE < 1) begin : g_bad_param
            $error("latch_checker: LAT must be 1..4 and SETTLE >= 1");
        end
    endgenerate

    logic [1:0]       state_reg, state_next;
    logic [SET_W-1:0] settle_cnt_reg;
    logic [CNT_W-1:0] sample_cnt_reg;
    logic [CNT_W-1:0] err_cnt_reg;
    logic [CNT_W-1:0] first_err_reg;
    logic             first_err_vld_reg;
    logic             exp_dly;
    logic             exp_vld_dly;
    logic             compare_en;
    logic             mismatch;
    logic             sat_hit;
    logic             settle_last;

    latch_ref_model #(
        .LAT (LAT)
    ) u_ref (
        .clk         (clk),
        .rst         (rst),
        .clr         (start),
        .en          (en),
        .d           (d),
        .exp_dly     (exp_dly),
        .exp_vld_dly (exp_vld_dly)
    );

    assign compare_en  = (state_reg == ST_CHECK) && exp_vld_dly && !start;
    assign mismatch    = (q != exp_dly);
    assign sat_hit     = compare_en && (sample_cnt_reg == CNT_MAX - 1'b1);
    assign settle_last = (settle_cnt_reg == SET_W'(SETTLE - 1));

    // start wins everywhere, including over a simultaneous stop.
    always_comb begin
        state_next = state_reg;
        if (start) begin
            state_next = ST_SETTLE;
        end else begin
            case (state_reg)
                ST_SETTLE: if (settle_last)      state_next = ST_CHECK;
                ST_CHECK:  if (stop || sat_hit)  state_next = ST_DONE;
                default:   state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            settle_cnt_reg    <= '0;
            sample_cnt_reg    <= '0;
            err_cnt_reg       <= '0;
            first_err_reg     <= '0;
            first_err_vld_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start) begin
                settle_cnt_reg    <= '0;
                sample_cnt_reg    <= '0;
                err_cnt_reg       <= '0;
                first_err_reg     <= '0;
                first_err_vld_reg <= 1'b0;
            end else begin
                if (state_reg == ST_SETTLE) begin
                    settle_cnt_reg <= settle_cnt_reg + 1'b1;
                end
                if (compare_en) begin
                    sample_cnt_reg <= sample_cnt_reg + 1'b1;
                    if (mismatch) begin
                        if (err_cnt_reg != CNT_MAX) begin
                            err_cnt_reg <= err_cnt_reg + 1'b1;
                        end
                        if (!first_err_vld_reg) begin
                            first_err_reg     <= sample_cnt_reg;
                            first_err_vld_reg <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign busy          = (state_reg == ST_SETTLE) || (state_reg == ST_CHECK);
    assign done          = (state_reg == ST_DONE);
    assign pass          = done && (err_cnt_reg == '0) && (sample_cnt_reg != '0);
    assign sample_cnt    = sample_cnt_reg;
    assign err_cnt       = err_cnt_reg;
    assign first_err     = first_err_reg;
    assign first_err_vld = first_err_vld_reg;

endmodule

// File: tb/tb_latch_checker.sv
// Scoreboard bench for latch_checker: stimulus pushes the expected end-of-run
// statistics, a monitor pops and compares them whenever done rises.
`timescale 1ns/1ps
module tb_latch_checker;

    localparam int M_IDEAL  = 0;
    localparam int M_STUCK0 = 1;
    localparam int M_FOLLOW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, stop, en, d, q;
    logic start_s, q_s;
    logic stop_s = 1'b0;
    logic busy, done, pass, first_err_vld;
    logic [15:0] sample_cnt, err_cnt, first_err;
    logic busy_s, done_s, pass_s, first_err_vld_s;
    logic [3:0] sample_cnt_s, err_cnt_s, first_err_s;

    int   mode = M_IDEAL;
    logic lat_state = 1'b0;
    logic d_prev = 1'b0;

    // Emulated latch under test: output appears one cycle after en/d.
    always @(posedge clk) begin
        lat_state <= en ? d : lat_state;
        d_prev    <= d;
    end
    assign q   = (mode == M_STUCK0) ? 1'b0 : (mode == M_FOLLOW) ? d_prev : lat_state;
    assign q_s = ~lat_state;

    latch_checker #(.LAT(1), .CNT_W(16), .SETTLE(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .d(d), .q(q),
        .busy(busy), .done(done), .pass(pass), .sample_cnt(sample_cnt),
        .err_cnt(err_cnt), .first_err(first_err), .first_err_vld(first_err_vld)
    );

    latch_checker #(.LAT(1), .CNT_W(4), .SETTLE(2)) u_sat (
        .clk(clk), .rst(rst), .start(start_s), .stop(stop_s), .en(en), .d(d), .q(q_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .sample_cnt(sample_cnt_s),
        .err_cnt(err_cnt_s), .first_err(first_err_s), .first_err_vld(first_err_vld_s)
    );

    typedef struct {
        string nm;
        int    sc;
        int    ec;
        int    fe;
        int    fev;
        int    ps;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_errors++;
            $display("FAIL %s got %0d want %0d", name, act, want);
        end
    endtask

    task automatic cmp_result(input exp_t e, input int sc, input int ec, input int fe,
                              input int fev, input int ps);
        chk({e.nm, "_sample_cnt"}, sc, e.sc);
        chk({e.nm, "_err_cnt"}, ec, e.ec);
        chk({e.nm, "_first_err"}, fe, e.fe);
        chk({e.nm, "_first_err_vld"}, fev, e.fev);
        chk({e.nm, "_pass"}, ps, e.ps);
        $display("result %s: sample=%0d err=%0d first=%0d vld=%0d pass=%0d",
                 e.nm, sc, ec, fe, fev, ps);
    endtask

    logic done_d = 1'b0;
    logic done_s_d = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1 && done_d !== 1'b1) begin
            if (q1.size() == 0) chk("main_unexpected_done", 1, 0);
            else begin
                e = q1.pop_front();
                cmp_result(e, int'(sample_cnt), int'(err_cnt), int'(first_err),
                           int'(first_err_vld), int'(pass));
            end
        end
        if (done_s === 1'b1 && done_s_d !== 1'b1) begin
            if (q2.size() == 0) chk("sat_unexpected_done", 1, 0);
            else begin
                e = q2.pop_front();
                cmp_result(e, int'(sample_cnt_s), int'(err_cnt_s), int'(first_err_s),
                           int'(first_err_vld_s), int'(pass_s));
            end
        end
        done_d   = done;
        done_s_d = done_s;
    end

    task automatic cyc(input logic e, input logic dd, input logic st, input logic sp);
        en    = e;
        d     = dd;
        start = st;
        stop  = sp;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_sample_cnt"}, int'(sample_cnt), 0);
        chk({tag, "_err_cnt"}, int'(err_cnt), 0);
        chk({tag, "_first_err"}, int'(first_err), 0);
        chk({tag, "_first_err_vld"}, int'(first_err_vld), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; start_s = 1'b0; en = 1'b0; d = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all_zero("reset");
        chk("reset_sat_busy", int'(busy_s), 0);

        // Ideal latch, random stimulus, 200 compares.
        mode = M_IDEAL;
        q1.push_back('{nm: "ideal", sc: 200, ec: 0, fe: 0, fev: 0, ps: 1});
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("start_busy", int'(busy), 1);
        repeat (2) cyc(1'b1, rbit(), 1'b0, 1'b0);
        repeat (199) cyc(rbit(), rbit(), 1'b0, 1'b0);
        cyc(rbit(), rbit(), 1'b0, 1'b1);
        chk("stop_done", int'(done), 1);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Stuck-at-0 latch.
        mode = M_STUCK0;
        q1.push_back('{nm: "stuck0", sc: 10, ec: 10, fe: 0, fev: 1, ps: 0});
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (9) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Gate low for 20 cycles: predictions invalid until en rises.
        mode = M_IDEAL;
        q1.push_back('{nm: "gate_low", sc: 5, ec: 0, fe: 0, fev: 0, ps: 1});
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (20) cyc(1'b0, rbit(), 1'b0, 1'b0);
        repeat (5) cyc(1'b1, rbit(), 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Hold: load 1, then gate closed with d toggling 0,1,0,1,...
        q1.push_back('{nm: "hold_ok", sc: 8, ec: 0, fe: 0, fev: 0, ps: 1});
        q1.push_back('{nm: "hold_follow", sc: 8, ec: 4, fe: 1, fev: 1, ps: 0});
        for (int pass_i = 0; pass_i < 2; pass_i++) begin
            mode = (pass_i == 0) ? M_IDEAL : M_FOLLOW;
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 7; i++) cyc(1'b0, 1'(i % 2), 1'b0, 1'b0);
            cyc(1'b0, 1'b1, 1'b0, 1'b1);
            repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Saturation on the 4-bit instance with an always-wrong latch.
        q2.push_back('{nm: "sat", sc: 15, ec: 15, fe: 0, fev: 1, ps: 0});
        start_s = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        start_s = 1'b0;
        for (int i = 0; i < 40 && done_s !== 1'b1; i++) cyc(1'b1, rbit(), 1'b0, 1'b0);
        chk("sat_auto_done", int'(done_s), 1);
        repeat (3) cyc(1'b1, rbit(), 1'b0, 1'b0);
        chk("sat_hold_sample", int'(sample_cnt_s), 15);

        // start and stop together in CHECK: restart wins.
        mode = M_IDEAL;
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("restart_busy", int'(busy), 1);
        chk("restart_done", int'(done), 0);
        chk("restart_sample_cnt", int'(sample_cnt), 0);
        q1.push_back('{nm: "restart", sc: 4, ec: 0, fe: 0, fev: 0, ps: 1});
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, rbit(), 1'b0, 1'b0);
        cyc(1'b0, rbit(), 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // rst in the middle of a failing CHECK run.
        mode = M_STUCK0;
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_err_cnt", int'(err_cnt), 3);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        chk_all_zero("mid_rst");
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        chk("main_queue_drained", q1.size(), 0);
        chk("sat_queue_drained", q2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
